// File: rtl/bcd_scan_driver_if.sv
// Load/display bundle between the ALU result source, the BCD scan driver and the 7-seg decoder.
// The master side drives load/value/blank_lz; the slave side returns busy/done and the scan outputs.
interface bcd_scan_driver_if;
    logic        load;
    logic [15:0] value;
    logic        blank_lz;
    logic        busy;
    logic        done;
    logic [3:0]  nibble;
    logic [4:0]  an;

    modport master (output load, value, blank_lz, input busy, done, nibble, an);
    modport slave  (input load, value, blank_lz, output busy, done, nibble, an);
endinterface

// File: rtl/bcd_scan_driver.sv
// Binary->5-digit BCD (double-dabble, 17-cycle busy, done pulse after) feeding a multiplexed 7-seg decoder.
// Latency: load to done = 18 cycles; backpressure: load is dropped (not queued) while busy.
module bcd_scan_driver #(
    parameter int CLK_DIV = 50000
) (
    input  logic           clk,
    input  logic           rst,
    bcd_scan_driver_if.slave bus
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t       state;
    logic [35:0]  sr;
    logic [35:0]  sr_adj;
    logic [3:0]   cnt;
    logic [19:0]  bcd_q;
    logic         busy_q;
    logic         done_q;

    logic [PW-1:0] presc;
    logic [2:0]    idx;
    logic          tick;
    logic [19:0]   upper;
    logic          blank;

    // Add-3 correction on every BCD field before the shift keeps each field <= 9 afterwards.
    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < 5; i++) begin
            if (sr[16 + 4*i +: 4] >= 4'd5)
                sr_adj[16 + 4*i +: 4] = sr[16 + 4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sr     <= '0;
            cnt    <= '0;
            bcd_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        sr     <= {20'b0, bus.value};
                        cnt    <= '0;
                        state  <= CONV;
                        busy_q <= 1'b1;
                    end
                end
                CONV: begin
                    sr  <= {sr_adj[34:0], 1'b0};
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15)
                        state <= DONE;
                end
                DONE: begin
                    // Whole-word update so the display never shows a partially converted value.
                    bcd_q  <= sr[35:16];
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign tick = (presc == PRE_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick)
                idx <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
        end
    end

    // upper holds digits idx..4 aligned to bit 0: its low nibble is the active digit.
    assign upper = bcd_q >> {idx, 2'b00};
    assign blank = bus.blank_lz && (idx != 3'd0) && (upper == 20'd0);

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.an     = ~(5'b00001 << idx);
    assign bus.nibble = blank ? 4'hF : upper[3:0];
endmodule
